// File: rtl/core_sequencer_pkg.sv
// +--------------------------------------------------------------------+
// | core_sequencer_pkg : state encoding, defaults, counter sizing      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package core_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_RESET_WAIT = 3'd0,
    ST_FETCH      = 3'd1,
    ST_EXECUTE    = 3'd2,
    ST_MEM_REQ    = 3'd3,
    ST_MEM_WAIT   = 3'd4,
    ST_WRITEBACK  = 3'd5,
    ST_PAUSE      = 3'd6,
    ST_HALT       = 3'd7
  } seq_state_e;

  localparam int unsigned DEFAULT_PAUSE_CYCLES = 16;
  localparam int unsigned DEFAULT_MEM_TIMEOUT  = 255;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_sequencer_cycle_counter.sv
// +--------------------------------------------------------------------+
// | sequencer_cycle_counter : loadable saturating up/down counter      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module sequencer_cycle_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Saturates at both ends so the count never wraps.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/core_sequencer.sv
// +--------------------------------------------------------------------+
// | core_sequencer : RV32I multi-cycle instruction sequencing FSM      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int unsigned PAUSE_CYCLES = DEFAULT_PAUSE_CYCLES,
  parameter int unsigned MEM_TIMEOUT  = DEFAULT_MEM_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rb_ready,
  input  logic       pc_end,
  input  logic       is_load,
  input  logic       is_store,
  input  logic       is_pause,
  input  logic       reg_w_dec,
  input  logic       bus_ready,
  input  logic       bus_busy,
  output logic       ir_load,
  output logic       bus_req,
  output logic       reg_w,
  output logic       pc_enable,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state
);

  localparam int unsigned        CNT_W        = cnt_width(PAUSE_CYCLES, MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]   PAUSE_LOAD   = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic             ir_load_q;
  logic             pc_enable_q;
  logic             halted_q;
  logic             fault_q;
  logic             fault_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_inc;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_count;
  logic             cnt_zero;
  logic             bus_ok;

  assign bus_ok = bus_ready && !bus_busy;

  always_comb begin
    state_d      = state_q;
    fault_d      = fault_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_inc      = 1'b0;
    cnt_dec      = 1'b0;
    case (state_q)
      ST_RESET_WAIT: begin
        if (rb_ready && bus_ready) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = pc_end ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (is_pause) begin
          state_d      = ST_PAUSE;
          cnt_load     = 1'b1;
          cnt_load_val = PAUSE_LOAD;
        end else if (is_load || is_store) begin
          state_d      = ST_MEM_REQ;
          cnt_load     = 1'b1;
          cnt_load_val = '0;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      // The timeout counter spans both bus states; a bus exit beats the timeout.
      ST_MEM_REQ: begin
        cnt_inc = 1'b1;
        if (bus_ok) begin
          state_d = ST_MEM_WAIT;
        end else if (cnt_count == TIMEOUT_LAST) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        cnt_inc = 1'b1;
        if (bus_ok) begin
          state_d = ST_WRITEBACK;
        end else if (cnt_count == TIMEOUT_LAST) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (cnt_zero) begin
          state_d = ST_WRITEBACK;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WRITEBACK: begin
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RESET_WAIT;
      end
    endcase
  end

  // State-decoded outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RESET_WAIT;
      ir_load_q   <= 1'b0;
      pc_enable_q <= 1'b0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_load_q   <= (state_d == ST_FETCH);
      pc_enable_q <= (state_d == ST_WRITEBACK);
      halted_q    <= (state_d == ST_HALT);
      fault_q     <= fault_d;
    end
  end

  sequencer_cycle_counter #(
    .WIDTH (CNT_W)
  ) u_cycle_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .inc_i      (cnt_inc),
    .dec_i      (cnt_dec),
    .count_o    (cnt_count),
    .zero_o     (cnt_zero)
  );

  assign ir_load   = ir_load_q;
  assign pc_enable = pc_enable_q;
  assign reg_w     = pc_enable_q && reg_w_dec;
  assign bus_req   = (state_q == ST_MEM_REQ) && bus_ok;
  assign halted    = halted_q;
  assign fault     = fault_q;
  assign state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_core_sequencer.sv
// +--------------------------------------------------------------------+
// | tb_core_sequencer : scoreboard bench for core_sequencer            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_core_sequencer;

  localparam int unsigned PAUSE_CYCLES = 16;
  localparam int unsigned MEM_TIMEOUT  = 8;

  localparam logic [2:0] S_RW = 3'd0, S_FE = 3'd1, S_EX = 3'd2, S_MR = 3'd3,
                         S_MW = 3'd4, S_WB = 3'd5, S_PA = 3'd6, S_HA = 3'd7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rb_ready = 1'b0, pc_end = 1'b0, is_load = 1'b0, is_store = 1'b0;
  logic       is_pause = 1'b0, reg_w_dec = 1'b0, bus_ready = 1'b1, bus_busy = 1'b0;
  logic       ir_load, bus_req, reg_w, pc_enable, halted, fault;
  logic [2:0] state;

  always #5 clk = ~clk;

  core_sequencer #(
    .PAUSE_CYCLES (PAUSE_CYCLES),
    .MEM_TIMEOUT  (MEM_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rb_ready  (rb_ready),
    .pc_end    (pc_end),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_pause  (is_pause),
    .reg_w_dec (reg_w_dec),
    .bus_ready (bus_ready),
    .bus_busy  (bus_busy),
    .ir_load   (ir_load),
    .bus_req   (bus_req),
    .reg_w     (reg_w),
    .pc_enable (pc_enable),
    .halted    (halted),
    .fault     (fault),
    .state     (state)
  );

  typedef struct packed {
    logic rst, rb, pce, ld, st, ps, rwd, brdy, bsy;
  } stim_t;

  stim_t      stim_q[$];
  logic [8:0] sb[$];
  int         checks = 0;
  int         failures = 0;

  function automatic logic [8:0] ex(input logic [2:0] st, input logic ir, input logic br,
                                    input logic rw, input logic pe, input logic h, input logic f);
    return {st, ir, br, rw, pe, h, f};
  endfunction

  function automatic stim_t mk(input logic r, input logic rb, input logic pce, input logic ld,
                               input logic st, input logic ps, input logic rwd,
                               input logic brdy, input logic bsy);
    stim_t s;
    s = '{rst: r, rb: rb, pce: pce, ld: ld, st: st, ps: ps, rwd: rwd, brdy: brdy, bsy: bsy};
    return s;
  endfunction

  function automatic logic [8:0] obs();
    return {state, ir_load, bus_req, reg_w, pc_enable, halted, fault};
  endfunction

  task automatic add(input stim_t s, input logic [8:0] e);
    stim_q.push_back(s);
    sb.push_back(e);
  endtask

  // Inputs settle mid-cycle; outputs are sampled before the edge that consumes them.
  task automatic apply(input stim_t s);
    #1;
    rst = s.rst; rb_ready = s.rb; pc_end = s.pce; is_load = s.ld; is_store = s.st;
    is_pause = s.ps; reg_w_dec = s.rwd; bus_ready = s.brdy; bus_busy = s.bsy;
    #1;
  endtask

  task automatic test_reset();
    stim_t s; logic [8:0] e, g; int n = 0;
    repeat (3) add(mk(1, 0, 0, 0, 0, 0, 0, 1, 0), ex(S_RW, 0, 0, 0, 0, 0, 0));
    repeat (4) add(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), ex(S_RW, 0, 0, 0, 0, 0, 0));
    add(mk(0, 1, 0, 0, 0, 0, 0, 1, 0), ex(S_RW, 0, 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); e = sb.pop_front(); g = obs(); checks++;
      if (g !== e) begin failures++; $display("FAIL reset step%0d got=%b exp=%b", n, g, e); end
      n++; @(posedge clk);
    end
  endtask

  task automatic test_alu();
    stim_t s; logic [8:0] e, g; int n = 0;
    add(mk(0, 1, 0, 0, 0, 0, 1, 1, 0), ex(S_FE, 1, 0, 0, 0, 0, 0));
    add(mk(0, 1, 0, 0, 0, 0, 1, 1, 0), ex(S_EX, 0, 0, 0, 0, 0, 0));
    add(mk(0, 1, 0, 0, 0, 0, 1, 1, 0), ex(S_WB, 0, 0, 1, 1, 0, 0));
    add(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), ex(S_FE, 1, 0, 0, 0, 0, 0));
    add(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), ex(S_EX, 0, 0, 0, 0, 0, 0));
    add(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), ex(S_WB, 0, 0, 0, 1, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); e = sb.pop_front(); g = obs(); checks++;
      if (g !== e) begin failures++; $display("FAIL alu step%0d got=%b exp=%b", n, g, e); end
      n++; @(posedge clk);
    end
  endtask

  task automatic test_load_busy();
    stim_t s; logic [8:0] e, g; int n = 0;
    add(mk(0, 1, 0, 1, 0, 0, 1, 1, 0), ex(S_FE, 1, 0, 0, 0, 0, 0));
    add(mk(0, 1, 0, 1, 0, 0, 1, 1, 0), ex(S_EX, 0, 0, 0, 0, 0, 0));
    add(mk(0, 1, 0, 1, 0, 0, 1, 1, 0), ex(S_MR, 0, 1, 0, 0, 0, 0));
    repeat (4) add(mk(0, 1, 0, 1, 0, 0, 1, 1, 1), ex(S_MW, 0, 0, 0, 0, 0, 0));
    add(mk(0, 1, 0, 1, 0, 0, 1, 1, 0), ex(S_MW, 0, 0, 0, 0, 0, 0));
    add(mk(0, 1, 0, 1, 0, 0, 1, 1, 0), ex(S_WB, 0, 0, 1, 1, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); e = sb.pop_front(); g = obs(); checks++;
      if (g !== e) begin failures++; $display("FAIL load_busy step%0d got=%b exp=%b", n, g, e); end
      n++; @(posedge clk);
    end
  endtask

  task automatic test_store_stall();
    stim_t s; logic [8:0] e, g; int n = 0;
    add(mk(0, 1, 0, 0, 1, 0, 0, 1, 0), ex(S_FE, 1, 0, 0, 0, 0, 0));
    add(mk(0, 1, 0, 0, 1, 0, 0, 1, 0), ex(S_EX, 0, 0, 0, 0, 0, 0));
    add(mk(0, 1, 0, 0, 1, 0, 0, 1, 1), ex(S_MR, 0, 0, 0, 0, 0, 0));
    add(mk(0, 1, 0, 0, 1, 0, 0, 1, 0), ex(S_MR, 0, 1, 0, 0, 0, 0));
    add(mk(0, 1, 0, 0, 1, 0, 0, 1, 0), ex(S_MW, 0, 0, 0, 0, 0, 0));
    add(mk(0, 1, 0, 0, 1, 0, 0, 1, 0), ex(S_WB, 0, 0, 0, 1, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); e = sb.pop_front(); g = obs(); checks++;
      if (g !== e) begin failures++; $display("FAIL store_stall step%0d got=%b exp=%b", n, g, e); end
      n++; @(posedge clk);
    end
  endtask

  // is_load is also raised to confirm pause takes priority.
  task automatic test_back_to_back();
    stim_t s; logic [8:0] e, g; int n = 0;
    for (int k = 0; k < 2; k++) begin
      add(mk(0, 1, 0, 1, 0, 1, 1, 1, 0), ex(S_FE, 1, 0, 0, 0, 0, 0));
      add(mk(0, 1, 0, 1, 0, 1, 1, 1, 0), ex(S_EX, 0, 0, 0, 0, 0, 0));
      repeat (PAUSE_CYCLES) add(mk(0, 1, 0, 1, 0, 1, 1, 1, 0), ex(S_PA, 0, 0, 0, 0, 0, 0));
      add(mk(0, 1, 0, 1, 0, 1, 1, 1, 0), ex(S_WB, 0, 0, 1, 1, 0, 0));
    end
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); e = sb.pop_front(); g = obs(); checks++;
      if (g !== e) begin failures++; $display("FAIL pause_b2b step%0d got=%b exp=%b", n, g, e); end
      n++; @(posedge clk);
    end
  endtask

  task automatic test_pause_reset();
    stim_t s; logic [8:0] e, g; int n = 0;
    add(mk(0, 1, 0, 0, 0, 1, 1, 1, 0), ex(S_FE, 1, 0, 0, 0, 0, 0));
    add(mk(0, 1, 0, 0, 0, 1, 1, 1, 0), ex(S_EX, 0, 0, 0, 0, 0, 0));
    repeat (4) add(mk(0, 1, 0, 0, 0, 1, 1, 1, 0), ex(S_PA, 0, 0, 0, 0, 0, 0));
    add(mk(1, 1, 0, 0, 0, 1, 1, 1, 0), ex(S_PA, 0, 0, 0, 0, 0, 0));
    add(mk(0, 1, 0, 0, 0, 0, 1, 1, 0), ex(S_RW, 0, 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); e = sb.pop_front(); g = obs(); checks++;
      if (g !== e) begin failures++; $display("FAIL pause_reset step%0d got=%b exp=%b", n, g, e); end
      n++; @(posedge clk);
    end
  endtask

  task automatic test_timeout();
    stim_t s; logic [8:0] e, g; int n = 0;
    add(mk(0, 1, 0, 0, 1, 0, 1, 0, 0), ex(S_FE, 1, 0, 0, 0, 0, 0));
    add(mk(0, 1, 0, 0, 1, 0, 1, 0, 0), ex(S_EX, 0, 0, 0, 0, 0, 0));
    repeat (MEM_TIMEOUT) add(mk(0, 1, 0, 0, 1, 0, 1, 0, 0), ex(S_MR, 0, 0, 0, 0, 0, 0));
    repeat (2) add(mk(0, 1, 0, 0, 1, 0, 1, 0, 0), ex(S_HA, 0, 0, 0, 0, 1, 1));
    add(mk(0, 1, 0, 0, 0, 0, 1, 1, 0), ex(S_HA, 0, 0, 0, 0, 1, 1));
    add(mk(1, 1, 0, 0, 0, 0, 0, 1, 0), ex(S_HA, 0, 0, 0, 0, 1, 1));
    add(mk(0, 1, 0, 0, 0, 0, 0, 1, 0), ex(S_RW, 0, 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); e = sb.pop_front(); g = obs(); checks++;
      if (g !== e) begin failures++; $display("FAIL timeout step%0d got=%b exp=%b", n, g, e); end
      n++; @(posedge clk);
    end
  endtask

  task automatic test_pc_end();
    stim_t s; logic [8:0] e, g; int n = 0;
    add(mk(0, 1, 0, 0, 0, 0, 1, 1, 0), ex(S_FE, 1, 0, 0, 0, 0, 0));
    add(mk(0, 1, 1, 0, 0, 0, 1, 1, 0), ex(S_EX, 0, 0, 0, 0, 0, 0));
    add(mk(0, 1, 1, 0, 0, 0, 1, 1, 0), ex(S_WB, 0, 0, 1, 1, 0, 0));
    add(mk(0, 1, 1, 0, 0, 0, 1, 1, 0), ex(S_FE, 1, 0, 0, 0, 0, 0));
    repeat (2) add(mk(0, 1, 1, 0, 0, 0, 1, 1, 0), ex(S_HA, 0, 0, 0, 0, 1, 0));
    add(mk(1, 1, 0, 0, 0, 0, 1, 1, 0), ex(S_HA, 0, 0, 0, 0, 1, 0));
    add(mk(0, 1, 0, 0, 0, 0, 1, 1, 0), ex(S_RW, 0, 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); e = sb.pop_front(); g = obs(); checks++;
      if (g !== e) begin failures++; $display("FAIL pc_end step%0d got=%b exp=%b", n, g, e); end
      n++; @(posedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    test_reset();
    test_alu();
    test_load_busy();
    test_store_stall();
    test_back_to_back();
    test_pause_reset();
    test_timeout();
    test_pc_end();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
